// File: rtl/de_watermark_stream.sv
// de_watermark_stream: reversible difference-expansion watermark embedder
// for a stream of pixel pairs, with a two-stage registered pipeline.
module de_watermark_stream #(
    parameter int DW     = 8,
    parameter int NCH    = 3,
    parameter int EMB_CH = 0,
    parameter int WMW    = 8,
    parameter int CW     = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*DW-1:0] in_pix0,
    input  logic [NCH*DW-1:0] in_pix1,
    input  logic              in_last,
    input  logic              wm_valid,
    output logic              wm_ready,
    input  logic [WMW-1:0]    wm_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH*DW-1:0] out_pix0,
    output logic [NCH*DW-1:0] out_pix1,
    output logic [NCH-1:0]    out_map,
    output logic              out_last,
    output logic              frame_done,
    output logic [CW-1:0]     emb_count,
    output logic [CW-1:0]     skip_count
);
    localparam int PW = NCH * DW;
    localparam int BW = 2 * WMW;
    localparam int OW = $clog2(BW + 1);
    localparam int SW = DW + 3;
    localparam logic signed [SW-1:0] ONE = 1;

    logic [BW-1:0]  bits_q, bits_d, bits_sh;
    logic [OW-1:0]  occ_q, occ_d, rem, need, used;
    logic [NCH-1:0] elig, e_map;
    logic [PW-1:0]  e_pix0, e_pix1;
    logic signed [SW-1:0] x0, x1, avg, dn, n0, n1, bs;

    logic           s1_v_q, s1_last_q;
    logic [PW-1:0]  s1_p0_q, s1_p1_q;
    logic [NCH-1:0] s1_map_q, s1_elig_q;
    logic           s2_v_q, s2_last_q;
    logic [PW-1:0]  s2_p0_q, s2_p1_q;
    logic [NCH-1:0] s2_map_q, s2_elig_q;
    logic [CW-1:0]  run_e_q, run_s_q, emb_q, skip_q;
    logic [CW-1:0]  sum_e, sum_s;
    logic           done_q;
    logic           in_fire, wm_fire, out_fire, s1_en, s2_en;

    always_comb begin
        elig = '0;
        need = '0;
        unique case (mode)
            2'd1: begin
                elig[EMB_CH] = 1'b1;
                need = OW'(1);
            end
            2'd2: begin
                elig = '1;
                need = OW'(NCH);
            end
            default: ;
        endcase
    end

    // each successfully expanded channel takes the next buffered bit
    always_comb begin
        e_pix0  = in_pix0;
        e_pix1  = in_pix1;
        e_map   = '0;
        used    = '0;
        x0      = '0;
        x1      = '0;
        avg     = '0;
        dn      = '0;
        n0      = '0;
        n1      = '0;
        bs      = '0;
        bits_sh = '0;
        for (int k = 0; k < NCH; k++) begin
            bits_sh = bits_q >> used;
            bs  = {{(SW-1){1'b0}}, bits_sh[0]};
            x0  = {3'b000, in_pix0[k*DW +: DW]};
            x1  = {3'b000, in_pix1[k*DW +: DW]};
            avg = (x0 + x1) >>> 1;
            dn  = ((x0 - x1) <<< 1) + bs;
            n0  = avg + ((dn + ONE) >>> 1);
            n1  = avg - (dn >>> 1);
            if (elig[k] && n0[SW-1:DW] == '0
                && n1[SW-1:DW] == '0) begin
                e_pix0[k*DW +: DW] = n0[DW-1:0];
                e_pix1[k*DW +: DW] = n1[DW-1:0];
                e_map[k] = 1'b1;
                used = used + OW'(1);
            end
        end
    end

    // consumed bits leave from the bottom; a loaded word lands above the rest
    always_comb begin
        rem    = occ_q - (in_fire ? used : '0);
        bits_d = bits_q >> (in_fire ? used : '0);
        occ_d  = rem;
        if (wm_fire) begin
            bits_d = bits_d | ({{WMW{1'b0}}, wm_data} << rem);
            occ_d  = rem + OW'(WMW);
        end
    end

    assign s2_en    = !s2_v_q || out_ready;
    assign s1_en    = !s1_v_q || s2_en;
    assign in_ready = !HRESET && s1_en && (occ_q >= need);
    assign wm_ready = (occ_q <= OW'(WMW));
    assign in_fire  = in_valid && in_ready;
    assign wm_fire  = wm_valid && wm_ready;
    assign out_fire = s2_v_q && out_ready;

    function automatic logic [CW-1:0] sat_add(
        input logic [CW-1:0]  a,
        input logic [NCH-1:0] m
    );
        logic [CW:0] s;
        s = {1'b0, a};
        for (int k = 0; k < NCH; k++)
            s = s + {{CW{1'b0}}, m[k]};
        return s[CW] ? '1 : s[CW-1:0];
    endfunction

    assign sum_e = sat_add(run_e_q, s2_map_q);
    assign sum_s = sat_add(run_s_q, s2_elig_q & ~s2_map_q);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            bits_q    <= '0;
            occ_q     <= '0;
            s1_v_q    <= 1'b0;
            s1_p0_q   <= '0;
            s1_p1_q   <= '0;
            s1_map_q  <= '0;
            s1_elig_q <= '0;
            s1_last_q <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_p0_q   <= '0;
            s2_p1_q   <= '0;
            s2_map_q  <= '0;
            s2_elig_q <= '0;
            s2_last_q <= 1'b0;
            run_e_q   <= '0;
            run_s_q   <= '0;
            emb_q     <= '0;
            skip_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            bits_q <= bits_d;
            occ_q  <= occ_d;
            if (s1_en) begin
                s1_v_q <= in_fire;
                if (in_fire) begin
                    s1_p0_q   <= e_pix0;
                    s1_p1_q   <= e_pix1;
                    s1_map_q  <= e_map;
                    s1_elig_q <= elig;
                    s1_last_q <= in_last;
                end
            end
            if (s2_en) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    s2_p0_q   <= s1_p0_q;
                    s2_p1_q   <= s1_p1_q;
                    s2_map_q  <= s1_map_q;
                    s2_elig_q <= s1_elig_q;
                    s2_last_q <= s1_last_q;
                end
            end
            done_q <= out_fire && s2_last_q;
            if (out_fire) begin
                if (s2_last_q) begin
                    emb_q   <= sum_e;
                    skip_q  <= sum_s;
                    run_e_q <= '0;
                    run_s_q <= '0;
                end else begin
                    run_e_q <= sum_e;
                    run_s_q <= sum_s;
                end
            end
        end
    end

    assign out_valid  = s2_v_q;
    assign out_pix0   = s2_p0_q;
    assign out_pix1   = s2_p1_q;
    assign out_map    = s2_map_q;
    assign out_last   = s2_last_q;
    assign frame_done = done_q;
    assign emb_count  = emb_q;
    assign skip_count = skip_q;
endmodule

// File: tb/tb_de_watermark_stream.sv
// Bench for de_watermark_stream: queue-based reference model feeding
// a scoreboard that a separate monitor drains on output handshakes.
module tb_de_watermark_stream;
    localparam int DW     = 8;
    localparam int NCH    = 3;
    localparam int EMB_CH = 0;
    localparam int WMW    = 8;
    localparam int CW     = 16;
    localparam int PW     = NCH * DW;
    localparam int MAXV   = (1 << DW) - 1;
    localparam int CMAX   = (1 << CW) - 1;

    logic              HCLK = 1'b0;
    logic              HRESET = 1'b1;
    logic [1:0]        mode = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PW-1:0]     in_pix0 = '0;
    logic [PW-1:0]     in_pix1 = '0;
    logic              in_last = 1'b0;
    logic              wm_valid = 1'b0;
    logic              wm_ready;
    logic [WMW-1:0]    wm_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [PW-1:0]     out_pix0;
    logic [PW-1:0]     out_pix1;
    logic [NCH-1:0]    out_map;
    logic              out_last;
    logic              frame_done;
    logic [CW-1:0]     emb_count;
    logic [CW-1:0]     skip_count;

    de_watermark_stream #(
        .DW(DW), .NCH(NCH), .EMB_CH(EMB_CH), .WMW(WMW), .CW(CW)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pix0(in_pix0), .in_pix1(in_pix1), .in_last(in_last),
        .wm_valid(wm_valid), .wm_ready(wm_ready), .wm_data(wm_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pix0(out_pix0), .out_pix1(out_pix1),
        .out_map(out_map), .out_last(out_last),
        .frame_done(frame_done),
        .emb_count(emb_count), .skip_count(skip_count)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [PW-1:0]  p0;
        logic [PW-1:0]  p1;
        logic [NCH-1:0] map;
        logic           last;
        int             nelig;
    } exp_t;

    exp_t expq[$];
    bit   wmq[$];
    int   checks = 0;
    int   errors = 0;
    int   run_e = 0, run_s = 0, exp_emb = 0, exp_skip = 0;
    bit   exp_fd = 0;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t",
                     name, act, req, $time);
        end
    endtask

    function automatic int fdiv2(input int a);
        return (a >= 0) ? a / 2 : -((1 - a) / 2);
    endfunction

    function automatic logic [PW-1:0] px(input int r, input int g,
                                         input int b);
        return {DW'(b), DW'(g), DW'(r)};
    endfunction

    function automatic int pop(input logic [NCH-1:0] m);
        int n = 0;
        for (int k = 0; k < NCH; k++) n += int'(m[k]);
        return n;
    endfunction

    // difference expansion evaluated on plain integers
    task automatic model_pair(input logic [1:0] md,
                              input logic [PW-1:0] a,
                              input logic [PW-1:0] b,
                              input logic lst);
        exp_t e;
        e.p0 = a; e.p1 = b; e.map = '0; e.last = lst; e.nelig = 0;
        for (int k = 0; k < NCH; k++) begin
            int x0, x1, av, dn, n0, n1, bt;
            if (md == 2'd2 || (md == 2'd1 && k == EMB_CH)) begin
                e.nelig++;
                x0 = int'(a[k*DW +: DW]);
                x1 = int'(b[k*DW +: DW]);
                bt = (wmq.size() > 0) ? int'(wmq[0]) : 0;
                av = (x0 + x1) / 2;
                dn = 2 * (x0 - x1) + bt;
                n0 = av + fdiv2(dn + 1);
                n1 = av - fdiv2(dn);
                if (n0 >= 0 && n0 <= MAXV && n1 >= 0 && n1 <= MAXV
                    && wmq.size() > 0) begin
                    e.p0[k*DW +: DW] = DW'(n0);
                    e.p1[k*DW +: DW] = DW'(n1);
                    e.map[k] = 1'b1;
                    void'(wmq.pop_front());
                end
            end
        end
        expq.push_back(e);
    endtask

    task automatic cyc(input bit iv, input logic [1:0] md,
                       input logic [PW-1:0] a, input logic [PW-1:0] b,
                       input bit lst, input bit wv,
                       input logic [WMW-1:0] wd, input bit ordy,
                       output bit fired);
        int need;
        in_valid = iv; mode = md; in_pix0 = a; in_pix1 = b;
        in_last = lst; wm_valid = wv; wm_data = wd; out_ready = ordy;
        #2;
        need = (md == 2'd2) ? NCH : (md == 2'd1) ? 1 : 0;
        chk("wm_ready", 64'(wm_ready), 64'(wmq.size() <= WMW));
        chk("in_ready", 64'(in_ready),
            64'((wmq.size() >= need) && (ordy || expq.size() < 2)));
        fired = iv && in_ready;
        if (fired) model_pair(md, a, b, lst);
        if (wv && wm_ready)
            for (int i = 0; i < WMW; i++) wmq.push_back(wd[i]);
        @(negedge HCLK);
    endtask

    task automatic idle(input bit ordy);
        bit f;
        cyc(0, 2'd0, '0, '0, 0, 0, '0, ordy, f);
    endtask

    task automatic do_reset(input int n);
        HRESET = 1'b1; in_valid = 1'b0; wm_valid = 1'b0; out_ready = 1'b1;
        repeat (n) begin
            #2;
            chk("in_ready_rst", 64'(in_ready), 64'(0));
            expq.delete(); wmq.delete();
            run_e = 0; run_s = 0; exp_emb = 0; exp_skip = 0; exp_fd = 0;
            @(negedge HCLK);
        end
        HRESET = 1'b0;
    endtask

    task automatic gen(output logic [PW-1:0] a, output logic [PW-1:0] b);
        for (int k = 0; k < NCH; k++) begin
            int x, y;
            x = int'($urandom_range(0, MAXV));
            if ($urandom_range(0, 1) == 1)
                y = x + int'($urandom_range(0, 8)) - 4;
            else
                y = int'($urandom_range(0, MAXV));
            if (y < 0) y = 0;
            if (y > MAXV) y = MAXV;
            a[k*DW +: DW] = DW'(x);
            b[k*DW +: DW] = DW'(y);
        end
    endtask

    // monitor: pops the scoreboard on every output handshake
    bit            hold = 0;
    logic [PW-1:0] hp0, hp1;
    logic [NCH-1:0] hmap;
    exp_t          me;
    always begin
        @(negedge HCLK);
        #3;
        if (HRESET) begin
            hold = 0;
        end else begin
            chk("frame_done", 64'(frame_done), 64'(exp_fd));
            chk("emb_count", 64'(emb_count), 64'(exp_emb));
            chk("skip_count", 64'(skip_count), 64'(exp_skip));
            exp_fd = 0;
            if (hold) begin
                chk("hold_valid", 64'(out_valid), 64'(1));
                chk("hold_pix0", 64'(out_pix0), 64'(hp0));
                chk("hold_pix1", 64'(out_pix1), 64'(hp1));
                chk("hold_map", 64'(out_map), 64'(hmap));
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_output", 64'(1), 64'(0));
                end else begin
                    me = expq.pop_front();
                    chk("out_pix0", 64'(out_pix0), 64'(me.p0));
                    chk("out_pix1", 64'(out_pix1), 64'(me.p1));
                    chk("out_map", 64'(out_map), 64'(me.map));
                    chk("out_last", 64'(out_last), 64'(me.last));
                    run_e = run_e + pop(me.map);
                    run_s = run_s + me.nelig - pop(me.map);
                    if (run_e > CMAX) run_e = CMAX;
                    if (run_s > CMAX) run_s = CMAX;
                    if (me.last) begin
                        exp_emb = run_e; exp_skip = run_s;
                        run_e = 0; run_s = 0; exp_fd = 1;
                    end
                end
            end
            hold = out_valid && !out_ready;
            hp0 = out_pix0; hp1 = out_pix1; hmap = out_map;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit @%0t", $time);
        $fatal(1);
    end

    initial begin
        bit f, seen;
        int n;
        logic [PW-1:0] a, b;
        @(negedge HCLK);
        do_reset(2);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_pix0", 64'(out_pix0), 64'(0));
        chk("rst_out_pix1", 64'(out_pix1), 64'(0));
        chk("rst_out_map", 64'(out_map), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_wm_ready", 64'(wm_ready), 64'(1));

        // single-channel embed and latency
        cyc(0, 2'd0, '0, '0, 0, 1, 8'h01, 1, f);
        cyc(1, 2'd1, px(100, 40, 7), px(98, 41, 9), 0, 0, '0, 1, f);
        chk("m1_accept", 64'(f), 64'(1));
        chk("m1_lat1", 64'(out_valid), 64'(0));
        idle(1);
        chk("m1_lat2", 64'(out_valid), 64'(1));
        chk("m1_pix0", 64'(out_pix0), 64'(px(102, 40, 7)));
        chk("m1_pix1", 64'(out_pix1), 64'(px(97, 41, 9)));
        chk("m1_map", 64'(out_map), 64'(3'b001));
        idle(1);

        // all-channel embed waits for bits
        do_reset(1);
        cyc(1, 2'd2, px(100, 50, 10), px(98, 50, 12), 0, 0, '0, 1, f);
        chk("m2_stall", 64'(f), 64'(0));
        cyc(1, 2'd2, px(100, 50, 10), px(98, 50, 12), 0, 1, 8'h05, 1, f);
        chk("m2_stall_load", 64'(f), 64'(0));
        cyc(1, 2'd2, px(100, 50, 10), px(98, 50, 12), 0, 0, '0, 1, f);
        chk("m2_accept", 64'(f), 64'(1));
        cyc(1, 2'd2, px(100, 50, 10), px(98, 50, 12), 0, 0, '0, 1, f);
        chk("m2_second", 64'(f), 64'(1));
        chk("m2_map", 64'(out_map), 64'(3'b111));
        chk("m2_pix0", 64'(out_pix0), 64'(px(102, 50, 10)));
        chk("m2_pix1", 64'(out_pix1), 64'(px(97, 50, 13)));
        cyc(1, 2'd2, px(100, 50, 10), px(98, 50, 12), 0, 0, '0, 1, f);
        chk("m2_third_stall", 64'(f), 64'(0));
        repeat (3) idle(1);

        // four-pair frame with one overflow skip
        do_reset(1);
        cyc(0, 2'd0, '0, '0, 0, 1, 8'h07, 1, f);
        cyc(1, 2'd1, px(100, 1, 2), px(98, 3, 4), 0, 0, '0, 1, f);
        cyc(1, 2'd1, px(255, 1, 2), px(0, 3, 4), 0, 0, '0, 1, f);
        cyc(1, 2'd1, px(50, 1, 2), px(50, 3, 4), 0, 0, '0, 1, f);
        cyc(1, 2'd1, px(10, 1, 2), px(12, 3, 4), 1, 0, '0, 1, f);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            idle(1);
            if (frame_done === 1'b1) seen = 1;
        end
        chk("frame_done_seen", 64'(seen), 64'(1));
        chk("frame_emb", 64'(emb_count), 64'(3));
        chk("frame_skip", 64'(skip_count), 64'(1));
        idle(1);
        chk("frame_done_pulse", 64'(frame_done), 64'(0));

        // burst with output stall
        n = 0;
        for (int c = 0; c < 100 && n < 10; c++) begin
            gen(a, b);
            cyc(1, 2'd0, a, b, 0, 0, '0, !(c >= 3 && c < 8), f);
            if (f) n++;
        end
        chk("burst_sent", 64'(n), 64'(10));
        repeat (4) idle(1);
        chk("burst_drained", 64'(expq.size()), 64'(0));

        // reset with pairs in flight
        cyc(0, 2'd0, '0, '0, 0, 1, 8'hA5, 1, f);
        cyc(1, 2'd1, px(100, 1, 2), px(98, 3, 4), 0, 0, '0, 0, f);
        cyc(1, 2'd1, px(60, 1, 2), px(61, 3, 4), 0, 0, '0, 0, f);
        do_reset(1);
        chk("rst_flight_valid", 64'(out_valid), 64'(0));
        cyc(1, 2'd1, px(60, 1, 2), px(61, 3, 4), 0, 0, '0, 1, f);
        chk("rst_no_bits", 64'(f), 64'(0));
        cyc(1, 2'd0, px(60, 1, 2), px(61, 3, 4), 0, 0, '0, 1, f);
        chk("rst_recover", 64'(f), 64'(1));
        repeat (4) idle(1);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            gen(a, b);
            cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                a, b, $urandom_range(0, 11) == 0,
                $urandom_range(0, 2) == 0, 8'($urandom),
                $urandom_range(0, 3) != 0, f);
        end
        repeat (10) idle(1);
        chk("final_drained", 64'(expq.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/de_watermark_stream.md
DE_WATERMARK_STREAM -- requirements
Module: de_watermark_stream

Parameters
REQ-001 SHALL provide DW, default 8, pixel channel width in bits.
REQ-002 SHALL provide NCH, default 3, channels per pixel, channel 0 = R.
REQ-003 SHALL provide EMB_CH, default 0, channel used in single-channel mode.
REQ-004 SHALL provide WMW, default 8, watermark load word width in bits.
REQ-005 SHALL provide CW, default 16, width of the status counters.

Interface
REQ-006 HCLK  in  1  sole clock, all state on rising edge.
REQ-007 HRESET  in  1  reset; one clock, synchronous, active-high.
REQ-008 mode  in  2  0 = bypass; 1 = embed in channel EMB_CH; 2 = embed in all channels; 3 = bypass.
REQ-009 in_valid/in_ready  in/out  1/1  pixel-pair handshake.
REQ-010 in_pix0, in_pix1  in  NCH*DW each  pixel pair, channel k at bits [k*DW +: DW].
REQ-011 in_last  in  1  final pair of frame.
REQ-012 wm_valid/wm_ready  in/out  1/1  watermark word handshake.
REQ-013 wm_data  in  WMW  watermark bits, consumed LSB first.
REQ-014 out_valid/out_ready  out/in  1/1  output handshake.
REQ-015 out_pix0, out_pix1  out  NCH*DW each  marked pixel pair.
REQ-016 out_map  out  NCH  location map; bit k = 1 if channel k carries a bit.
REQ-017 out_last  out  1  in_last delayed with its pair.
REQ-018 frame_done  out  1  one-cycle pulse after the out_last handshake.
REQ-019 emb_count, skip_count  out  CW each  previous-frame totals.

Function
REQ-020 A transfer SHALL occur only on a cycle with valid=1 and ready=1, on every port.
REQ-021 The bit buffer SHALL hold 2*WMW bits; wm_ready=1 when occupancy <= WMW; an accepted word appends above the existing bits.
REQ-022 mode SHALL be sampled on the input transfer and travel with that pair; a mid-stream change affects only later pairs.
REQ-023 In embed modes, in_ready SHALL be 0 while buffer occupancy < channels needed (1 or NCH); in bypass no bits are needed.
REQ-024 Per embedded channel, with x0,x1 unsigned and b the next buffer bit: avg=floor((x0+x1)/2); d=x0-x1; dn=2d+b; n0=avg+floor((dn+1)/2); n1=avg-floor(dn/2); signed, DW+3 bits, floor division.
REQ-025 If 0 <= n0,n1 <= 2^DW-1: output n0,n1, map bit=1, b consumed; otherwise pass x0,x1, map bit=0, b not consumed.
REQ-026 Channels SHALL use bits in ascending channel order, each successful channel taking the next bit.
REQ-027 Non-embedded channels and bypass pairs SHALL pass unchanged with map bit 0.
REQ-028 A same-cycle word load and bit consumption SHALL give occupancy = old + WMW - consumed.
REQ-029 Pipeline: two registered stages; with out_ready held 1, out_valid SHALL rise exactly 2 cycles after the input transfer.
REQ-030 Full throughput: one pair per cycle while out_ready=1 and bits suffice.
REQ-031 When out_ready=0, out_valid, data and map SHALL hold; the pipeline fills, then in_ready drops; no pair lost or duplicated.
REQ-032 Internal running counters SHALL count embedded bits and skipped embed-eligible channels per output transfer, saturating at 2^CW-1.
REQ-033 On the out_last transfer, emb_count/skip_count SHALL load the frame totals including that pair; running counters clear; frame_done=1 on the next cycle only.

Reset
REQ-034 On HRESET=1 at an edge: pipeline empty, buffer occupancy 0, out_valid=0, out_pix0/out_pix1/out_map/out_last=0, in_ready=0, wm_ready=1, frame_done=0, all counters 0.
REQ-035 Reset mid-frame SHALL discard in-flight pairs and buffered bits with no output transfer; in_ready SHALL recover the cycle after HRESET falls.

Verification
REQ-036 Mode 1, EMB_CH=0, R0=100, R1=98, bit 1 -> out R0=102, R1=97, out_map=001, G/B unchanged, out_valid 2 cycles after input.
REQ-037 Mode 1, R0=255, R1=0, bit 1 -> R pass unchanged, out_map=000, bit retained for the next pair, skip_count +1 at frame end.
REQ-038 Mode 2, empty buffer, in_valid=1 -> in_ready=0; load wm_data=0x05 -> pair accepted, R/G/B embed bits 1,0,1, occupancy 5.
REQ-039 out_ready=0 for 5 cycles during a 10-pair burst -> outputs held stable, all 10 pairs emerge in order, none lost or duplicated.
REQ-040 4-pair frame, 3 embeds, 1 skip, in_last on pair 4 -> frame_done one cycle, emb_count=3, skip_count=1.
REQ-041 HRESET pulse with 2 pairs in flight -> out_valid=0 next cycle, occupancy 0, no stale output afterward.
